// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// time_set_ctrl : debounced front-panel controller that edits the clock time
//                 and programs/arms the alarm through a five-state edit FSM
// Revision      : 1.0
// ============================================================================
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 120
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [16:0] counter_state,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_alarm,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time,
  output logic [2:0]  edit_field
);

  localparam int unsigned       c_db_w         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_max       = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]       c_timeout_last = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]       c_day_last     = 17'd86399;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_ALM_HR  = 3'd3,
    ST_ALM_MIN = 3'd4
  } state_t;

  logic [3:0] w_btn_raw;
  logic [3:0] w_press;

  assign w_btn_raw = {btn_alarm, btn_down, btn_up, btn_mode};

  // Per button: 2-flop synchronizer, stability counter, registered press pulse.
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic [c_db_w-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == c_db_max) begin
          level_d = sync2_q;
          press_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= w_btn_raw[gi];
        sync2_q <= sync1_q;
        level_q <= level_d;
        press_q <= press_d;
        cnt_q   <= cnt_d;
      end
    end

    assign w_press[gi] = press_q;
  end

  logic w_mode_ev, w_alarm_ev, w_updn_ok, w_up_ev, w_down_ev, w_any_ev;

  assign w_mode_ev  = w_press[0];
  assign w_alarm_ev = w_press[3] & ~w_press[0];
  assign w_updn_ok  = ~w_press[0] & ~w_press[3] & (w_press[1] ^ w_press[2]);
  assign w_up_ev    = w_updn_ok & w_press[1];
  assign w_down_ev  = w_updn_ok & w_press[2];
  assign w_any_ev   = |w_press;

  function automatic logic [16:0] hour_step(input logic [16:0] t, input logic up);
    if (up) return (t <= 17'd82799) ? t + 17'd3600 : t - 17'd82800;
    else    return (t >= 17'd3600)  ? t - 17'd3600 : t + 17'd82800;
  endfunction

  function automatic logic [16:0] minute_step(input logic [16:0] t, input logic up);
    logic [16:0] mins;
    mins = (t / 17'd60) % 17'd60;
    // Minute wraps inside the same hour; no carry into the hour field.
    if (up) return (mins < 17'd59) ? t + 17'd60 : t - 17'd3540;
    else    return (mins > 17'd0)  ? t - 17'd60 : t + 17'd3540;
  endfunction

  state_t      state_q, state_d;
  logic [16:0] set_time_q, set_time_d;
  logic [16:0] alarm_time_q, alarm_time_d;
  logic        alarm_en_q, alarm_en_d;
  logic        set_flag_q, set_flag_d;
  logic        alarm_flag_q, alarm_flag_d;
  logic [31:0] idle_q, idle_d;

  always_comb begin
    state_d      = state_q;
    set_time_d   = set_time_q;
    alarm_time_d = alarm_time_q;
    alarm_en_d   = alarm_en_q;
    if (state_q == ST_RUN || w_any_ev) idle_d = '0;
    else                               idle_d = idle_q + 32'd1;

    if (w_mode_ev) begin
      idle_d = '0;
      case (state_q)
        ST_RUN: begin
          state_d    = ST_SET_HR;
          set_time_d = (counter_state > c_day_last) ? 17'd0 : counter_state;
        end
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_ALM_HR;
        ST_ALM_HR:  state_d = ST_ALM_MIN;
        ST_ALM_MIN: begin
          state_d    = ST_RUN;
          alarm_en_d = 1'b1;
        end
        default:    state_d = ST_RUN;
      endcase
    end else if (w_alarm_ev) begin
      if (state_q == ST_RUN) alarm_en_d = ~alarm_en_q;
    end else if (w_up_ev || w_down_ev) begin
      case (state_q)
        ST_SET_HR:  set_time_d   = hour_step(set_time_q, w_up_ev);
        ST_SET_MIN: set_time_d   = minute_step(set_time_q, w_up_ev);
        ST_ALM_HR:  alarm_time_d = hour_step(alarm_time_q, w_up_ev);
        ST_ALM_MIN: alarm_time_d = minute_step(alarm_time_q, w_up_ev);
        default:    ;
      endcase
    end else if (!w_any_ev && state_q != ST_RUN && idle_q >= c_timeout_last) begin
      // alarm_en cannot change during an edit, so it already holds the pre-edit value.
      state_d = ST_RUN;
    end

    set_flag_d   = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN);
    alarm_flag_d = alarm_en_d && !((state_d == ST_ALM_HR) || (state_d == ST_ALM_MIN));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      set_time_q   <= '0;
      alarm_time_q <= '0;
      alarm_en_q   <= 1'b0;
      set_flag_q   <= 1'b0;
      alarm_flag_q <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      set_time_q   <= set_time_d;
      alarm_time_q <= alarm_time_d;
      alarm_en_q   <= alarm_en_d;
      set_flag_q   <= set_flag_d;
      alarm_flag_q <= alarm_flag_d;
      idle_q       <= idle_d;
    end
  end

  assign set_flag   = set_flag_q;
  assign set_time   = set_time_q;
  assign alarm_flag = alarm_flag_q;
  assign alarm_time = alarm_time_q;
  assign edit_field = state_q;

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven setting controller that sequences the time counter and alarm blocks. It debounces four raw front-panel buttons and runs a five-state edit FSM. While the time is being set, it holds the counter through the set_flag/set_time load path; it also programs and arms the alarm through alarm_flag/alarm_time. It replaces the testbench stimulus source in the top level: its outputs connect directly to the counter's and alarm's set and alarm inputs, and its counter_state input connects to the counter's output.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a debounced level changes; minimum 1.
- TIMEOUT_CYCLES, 120: idle cycles in any edit state before auto-exit to RUN; minimum 1. The idle counter is 32 bits.
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- counter_state  in  17  current timestamp, in seconds since 12:00:00 AM, range 0..86399.
- btn_mode  in  1  raw, asynchronous; advances the edit state.
- btn_up  in  1  raw; increments the field being edited.
- btn_down  in  1  raw; decrements the field being edited.
- btn_alarm  in  1  raw; toggles the alarm enable while in RUN.
- set_flag  out  1  high while the time is being edited; the counter loads set_time every cycle.
- set_time  out  17  timestamp being edited.
- alarm_flag  out  1  alarm enable as seen by the alarm block.
- alarm_time  out  17  alarm setpoint.
- edit_field  out  3  state code: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 ALM_HR, 4 ALM_MIN.

## Operation
- Input conditioning, applied to each button:
  - 2-flop synchronizer.
  - Per-button counter. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - Press event: a one-cycle pulse on the 0→1 edge of the debounced level. Releases generate no event.
- Event priority within one cycle:
  - mode > alarm > up/down.
  - Only the highest-priority event acts; the others are dropped.
  - up together with down is treated as no up/down event.
- FSM, with transitions taken on a mode event:
  - RUN → SET_HR: same edge captures set_time <= counter_state (a value >86399 is captured as 0) and sets set_flag <= 1.
  - SET_HR → SET_MIN.
  - SET_MIN → ALM_HR: set_flag <= 0; set_time keeps its last value.
  - ALM_HR → ALM_MIN.
  - ALM_MIN → RUN: sets alarm_en <= 1.
- Hour edit (SET_HR on set_time, ALM_HR on alarm_time), with t the value being edited:
  - up: t+3600 if t+3600 ≤ 86399, else t+3600−86400.
  - down: t−3600 if t ≥ 3600, else t+82800.
  - Minutes and seconds are preserved.
- Minute edit, with m = (t/60) mod 60:
  - up: t+60 if m<59, else t−3540.
  - down: t−60 if m>0, else t+3540.
  - Hour and seconds are preserved; there is no carry into the hour.
- Seconds are never edited; the captured seconds persist.
- All arithmetic is 17-bit unsigned. Results are always in 0..86399.
- alarm_en is an internal register:
  - An alarm event toggles it in RUN only; alarm events are ignored in every other state.
  - alarm_flag = alarm_en AND state ∉ {ALM_HR, ALM_MIN}. This forces the flag low while the alarm is edited, which clears any triggered alarm.
- Timeout:
  - The idle counter clears on any press event and on every entry to an edit state.
  - When it reaches TIMEOUT_CYCLES in an edit state, the FSM goes to RUN.
  - set_flag drops and the edited values are kept.
  - alarm_en is restored to its pre-edit value, not set.

## Timing
- Reset values: set_flag 0, set_time 0, alarm_flag 0, alarm_time 0, edit_field 0, alarm_en 0. Debounced levels are 0 and all counters are 0.
- Reset asserted mid-edit: all outputs go to their reset values immediately, asynchronously.
- Raw edge (held stable) to press event: 2 + DEBOUNCE_CYCLES cycles.
- Press event to output change: registered on the edge that samples the event, so the output is visible 1 cycle after the event.
- The state transition and the set_time capture happen on the same edge. The counter sees set_flag one cycle later and holds that value from then on.
- A held button generates exactly one event; there is no auto-repeat.
- A glitch shorter than DEBOUNCE_CYCLES generates no event.

## Test plan
All scenarios use DEBOUNCE_CYCLES=2 and TIMEOUT_CYCLES=50.
- Time hour/minute edit:
  - Stimulus: counter_state=34953; press mode, up, mode, down.
  - Response: after mode, set_flag=1, set_time=34953, edit_field=1. After up, set_time=38553, edit_field=1. After mode, edit_field=2. After down, set_time=38493.
- Hour wrap:
  - Stimulus: enter SET_HR with counter_state=84600; press up, then down.
  - Response: set_time 84600 → 1800 → 84600.
- Minute wrap:
  - Stimulus: enter SET_MIN with counter_state=35973; press up, then down.
  - Response: set_time 35973 → 32433 → 35973. Hour remains 9.
- Alarm program and arm:
  - Stimulus: from reset, press mode ×3 (edit_field=3, alarm_flag=0); up ×3; mode; down; mode; then btn_alarm.
  - Response: up ×3 gives alarm_time=10800. mode then down gives alarm_time=14340. The final mode gives edit_field=0 and alarm_flag=1. btn_alarm gives alarm_flag=0.
- Debounce and priority:
  - A 1-cycle btn_up glitch produces no change.
  - up+down pressed in the same cycle produces no change.
  - mode+up pressed in the same cycle produces only the state advance; set_time equals the captured value.
  - btn_alarm pressed in SET_HR has no effect on alarm_flag.
- Timeout and reset:
  - In SET_MIN, 50 idle cycles → edit_field=0, set_flag=0, set_time retained.
  - In ALM_HR with alarm_en previously 1, timeout → alarm_flag=1.
  - Asserting reset_n low in SET_HR clears all outputs to 0 immediately.
